writeback_stage: RTL and testbench

- MEM/WB pipeline register and write-back formatter for the 5-stage MIPS datapath.
- Captures memory-stage results, extracts and extends load data, and resolves the write-back source (ALU, load, or link).
- Drives the register file's write port (WAddr/WData/RegWrite) and exposes the same values to the forwarding unit.
- Keeps a sticky misalignment flag and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 16 +
 rtl/load_formatter.sv | 48 ++++
 rtl/writeback_stage.sv | 98 +++++++++
 tb/tb_writeback_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: write-back source select, load size, fixed register numbers.
// Pure definitions; no logic.
package mips_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/load_formatter.sv
// Little-endian sub-word load extraction with sign/zero extension and alignment check.
// Purely combinational; no state and no flow control.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = rd_word_i[15:8];
            2'd2:    byte_sel = rd_word_i[23:16];
            2'd3:    byte_sel = rd_word_i[31:24];
            default: byte_sel = rd_word_i[7:0];
        endcase
        half_sel = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    end

    // Reserved size encoding falls through to word behaviour.
    always_comb begin
        data_o       = rd_word_i;
        misaligned_o = (offset_i != 2'd0);
        case (size_i)
            LD_BYTE: begin
                data_o       = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                misaligned_o = 1'b0;
            end
            LD_HALF: begin
                data_o       = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            default: begin
                data_o       = rd_word_i;
                misaligned_o = (offset_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back formatter; 1-cycle registered latency.
// Flush inserts a bubble, Stall holds every output; sticky AlignErr and a wrapping retire counter.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             MemValid,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      MemReadData,
    input  logic [31:0]      PCPlus4,
    input  logic [4:0]       WAddrIn,
    input  logic             RegWriteIn,
    input  logic [1:0]       MemToReg,
    input  logic [1:0]       LoadSize,
    input  logic             LoadUnsigned,
    output logic [31:0]      WData,
    output logic [4:0]       WAddr,
    output logic             RegWrite,
    output logic             WbValid,
    output logic             AlignErr,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [4:0]       LINK_ADDR = 5'(LINK_REG);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      fmt_data;
    logic             fmt_mis;
    logic             mis;
    logic [31:0]      wdata_d, wdata_q;
    logic [4:0]       waddr_d, waddr_q;
    logic             we_d, we_q;
    logic             vld_q;
    logic             align_q;
    logic [CNT_W-1:0] ret_q;

    load_formatter u_fmt (
        .rd_word_i   (MemReadData),
        .offset_i    (ALUResult[1:0]),
        .size_i      (LoadSize),
        .unsigned_i  (LoadUnsigned),
        .data_o      (fmt_data),
        .misaligned_o(fmt_mis)
    );

    // Alignment only matters for actual loads; the reserved select behaves as ALU.
    always_comb begin
        mis     = (MemToReg == WB_MEM) & fmt_mis;
        wdata_d = ALUResult;
        waddr_d = WAddrIn;
        case (MemToReg)
            WB_MEM:  wdata_d = fmt_data;
            WB_LINK: begin
                wdata_d = PCPlus4 + 32'd4;
                waddr_d = LINK_ADDR;
            end
            default: wdata_d = ALUResult;
        endcase
        we_d = MemValid & RegWriteIn & ~mis & (waddr_d != REG_ZERO);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            vld_q   <= 1'b0;
            align_q <= 1'b0;
            ret_q   <= '0;
        end else if (Flush) begin
            we_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (!Stall) begin
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            vld_q   <= MemValid;
            align_q <= align_q | (MemValid & mis);
            if (MemValid) begin
                ret_q <= ret_q + CNT_ONE;
            end
        end
    end

    assign WData    = wdata_q;
    assign WAddr    = waddr_q;
    assign RegWrite = we_q;
    assign WbValid  = vld_q;
    assign AlignErr = align_q;
    assign Retired  = ret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second instance with a 4-bit counter exercises wrap-around.
module tb_writeback_stage;
    import mips_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n, Stall, Flush, MemValid, RegWriteIn, LoadUnsigned;
    logic [31:0] ALUResult, MemReadData, PCPlus4;
    logic [4:0]  WAddrIn;
    logic [1:0]  MemToReg, LoadSize;

    logic [31:0] WData, WData4;
    logic [4:0]  WAddr, WAddr4;
    logic        RegWrite, WbValid, AlignErr, RegWrite4, WbValid4, AlignErr4;
    logic [31:0] Retired;
    logic [3:0]  Retired4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_ret;

    always #5 Clk = ~Clk;

    writeback_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .MemValid(MemValid),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .PCPlus4(PCPlus4),
        .WAddrIn(WAddrIn), .RegWriteIn(RegWriteIn), .MemToReg(MemToReg),
        .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned),
        .WData(WData), .WAddr(WAddr), .RegWrite(RegWrite), .WbValid(WbValid),
        .AlignErr(AlignErr), .Retired(Retired)
    );

    writeback_stage #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .MemValid(MemValid),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .PCPlus4(PCPlus4),
        .WAddrIn(WAddrIn), .RegWriteIn(RegWriteIn), .MemToReg(MemToReg),
        .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned),
        .WData(WData4), .WAddr(WAddr4), .RegWrite(RegWrite4), .WbValid(WbValid4),
        .AlignErr(AlignErr4), .Retired(Retired4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] wa);
        MemValid   = 1'b1;
        RegWriteIn = 1'b1;
        MemToReg   = WB_ALU;
        ALUResult  = res;
        WAddrIn    = wa;
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[5];

    initial begin
        ld_tab[0] = '{"lb_off0",  LD_BYTE, 1'b0, 2'd0, 32'hFFFF_FFC2};
        ld_tab[1] = '{"lbu_off1", LD_BYTE, 1'b1, 2'd1, 32'h0000_00F1};
        ld_tab[2] = '{"lh_off2",  LD_HALF, 1'b0, 2'd2, 32'hFFFF_8033};
        ld_tab[3] = '{"lhu_off2", LD_HALF, 1'b1, 2'd2, 32'h0000_8033};
        ld_tab[4] = '{"lw_off0",  LD_WORD, 1'b0, 2'd0, 32'h8033_F1C2};

        Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; MemValid = 1'b0;
        ALUResult = '0; MemReadData = '0; PCPlus4 = '0; WAddrIn = '0;
        RegWriteIn = 1'b0; MemToReg = WB_ALU; LoadSize = LD_WORD; LoadUnsigned = 1'b0;
        exp_ret = '0;

        step();
        check("rst_wdata", WData, 32'h0);
        check("rst_waddr", {27'b0, WAddr}, 32'h0);
        check("rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("rst_wbvalid", {31'b0, WbValid}, 32'h0);
        check("rst_alignerr", {31'b0, AlignErr}, 32'h0);
        check("rst_retired", Retired, 32'h0);

        // Get RegWrite high, then pull reset mid-cycle.
        Rst_n = 1'b1;
        alu_op(32'h0000_00AB, 5'd8);
        step();
        check("pre_rst_regwrite", {31'b0, RegWrite}, 32'h1);
        Rst_n = 1'b0;
        #1;
        check("async_rst_wdata", WData, 32'h0);
        check("async_rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("async_rst_wbvalid", {31'b0, WbValid}, 32'h0);
        check("async_rst_retired", Retired, 32'h0);
        #1;
        Rst_n = 1'b1;

        step(); exp_ret = 32'd1;
        check("alu_wdata", WData, 32'h0000_00AB);
        check("alu_waddr", {27'b0, WAddr}, 32'd8);
        check("alu_regwrite", {31'b0, RegWrite}, 32'h1);
        check("alu_retired", Retired, exp_ret);

        MemReadData = 32'h8033_F1C2;
        MemToReg    = WB_MEM;
        WAddrIn     = 5'd9;
        foreach (ld_tab[i]) begin
            LoadSize     = ld_tab[i].size;
            LoadUnsigned = ld_tab[i].uns;
            ALUResult    = {30'h0000_1000, ld_tab[i].off};
            step(); exp_ret++;
            check(ld_tab[i].tag, WData, ld_tab[i].exp);
        end
        check("lw_regwrite", {31'b0, RegWrite}, 32'h1);
        check("load_retired", Retired, exp_ret);
        check("load_no_alignerr", {31'b0, AlignErr}, 32'h0);

        LoadSize = LD_HALF; LoadUnsigned = 1'b0; ALUResult = 32'h0000_1001;
        step(); exp_ret++;
        check("mis_regwrite", {31'b0, RegWrite}, 32'h0);
        check("mis_alignerr", {31'b0, AlignErr}, 32'h1);
        check("mis_wbvalid", {31'b0, WbValid}, 32'h1);
        check("mis_retired", Retired, exp_ret);

        MemValid = 1'b0; MemToReg = WB_ALU; ALUResult = 32'h0;
        repeat (10) step();
        check("mis_sticky_alignerr", {31'b0, AlignErr}, 32'h1);
        check("bubble_retired", Retired, exp_ret);
        check("bubble_wbvalid", {31'b0, WbValid}, 32'h0);

        MemValid = 1'b1; RegWriteIn = 1'b1; MemToReg = WB_LINK;
        PCPlus4 = 32'h0040_0010; WAddrIn = 5'd0;
        step(); exp_ret++;
        check("link_waddr", {27'b0, WAddr}, 32'd31);
        check("link_wdata", WData, 32'h0040_0014);
        check("link_regwrite", {31'b0, RegWrite}, 32'h1);

        Stall = 1'b1;
        alu_op(32'h0000_0055, 5'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_wdata", WData, 32'h0040_0014);
            check("stall_waddr", {27'b0, WAddr}, 32'd31);
            check("stall_retired", Retired, exp_ret);
        end

        Flush = 1'b1;
        step();
        check("flush_wbvalid", {31'b0, WbValid}, 32'h0);
        check("flush_regwrite", {31'b0, RegWrite}, 32'h0);

        Flush = 1'b0; Stall = 1'b0;
        alu_op(32'h0000_0077, 5'd0);
        step(); exp_ret++;
        check("r0_regwrite", {31'b0, RegWrite}, 32'h0);
        check("r0_wbvalid", {31'b0, WbValid}, 32'h1);
        check("r0_wdata", WData, 32'h0000_0077);
        check("r0_retired", Retired, exp_ret);

        alu_op(32'h0000_0011, 5'd26);
        step(); exp_ret++;
        check("k0_regwrite", {31'b0, RegWrite}, 32'h1);

        // Narrow counter: run up to its maximum, then one more retire must wrap to zero.
        for (int c = 0; c < 16 && exp_ret[3:0] != 4'hF; c++) begin
            step(); exp_ret++;
        end
        check("wrap_pre", {28'b0, Retired4}, 32'hF);
        step(); exp_ret++;
        check("wrap_zero", {28'b0, Retired4}, 32'h0);
        check("wide_no_wrap", Retired, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
